// File: rtl/schmitt_trigger_bank.sv
// Multi-channel hysteresis filter: optional input synchronizer, then a per-channel
// qualification FSM with independent rise/fall lengths, gated by a sample tick.
module schmitt_trigger_bank #(
  parameter int unsigned p_channels = 4,
  parameter int unsigned p_rise_len = 5,
  parameter int unsigned p_fall_len = 3,
  parameter int unsigned p_sync     = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_tick,
  input  logic [p_channels-1:0] i_in,
  output logic [p_channels-1:0] o_out,
  output logic [p_channels-1:0] o_rise,
  output logic [p_channels-1:0] o_fall,
  output logic [p_channels-1:0] o_busy
);

  localparam int unsigned MAX_LEN = (p_rise_len > p_fall_len) ? p_rise_len : p_fall_len;
  localparam int unsigned CW      = $clog2(MAX_LEN + 1);
  localparam int unsigned SW      = (p_sync > 0) ? $clog2(p_sync + 1) : 1;

  typedef enum logic [2:0] {
    ST_INIT = 3'd0,
    ST_LOW  = 3'd1,
    ST_RISE = 3'd2,
    ST_HIGH = 3'd3,
    ST_FALL = 3'd4
  } state_e;

  logic [p_channels-1:0] s;

  generate
    if (p_sync > 0) begin : g_sync
      logic [p_channels-1:0] sync_q [p_sync];
      logic [p_channels-1:0] sync_d [p_sync];

      always_comb begin
        sync_d[0] = i_in;
        for (int i = 1; i < int'(p_sync); i++) sync_d[i] = sync_q[i-1];
      end

      always_ff @(posedge i_clk) begin
        for (int i = 0; i < int'(p_sync); i++) begin
          if (i_rst) sync_q[i] <= '0;
          else       sync_q[i] <= sync_d[i];
        end
      end

      assign s = sync_q[p_sync-1];
    end else begin : g_bypass
      assign s = i_in;
    end
  endgenerate

  // Shared settle counter: INIT channels wait until the synchronizer has flushed.
  logic [SW-1:0] settle_q, settle_d;
  logic          settle_done;

  assign settle_done = (settle_q == SW'(p_sync));

  always_comb begin
    settle_d = settle_done ? settle_q : settle_q + SW'(1);
  end

  state_e                state_q [p_channels];
  state_e                state_d [p_channels];
  logic [CW-1:0]         cnt_q   [p_channels];
  logic [CW-1:0]         cnt_d   [p_channels];
  logic [p_channels-1:0] out_q, out_d, rise_q, rise_d, fall_q, fall_d, busy_q, busy_d;

  always_comb begin
    out_d  = '0;
    rise_d = '0;
    fall_d = '0;
    busy_d = '0;
    for (int c = 0; c < int'(p_channels); c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      if (i_tick) begin
        case (state_q[c])
          ST_INIT: begin
            if (settle_done) state_d[c] = s[c] ? ST_HIGH : ST_LOW;
            cnt_d[c] = '0;
          end
          ST_LOW: begin
            if (s[c]) begin
              if (p_rise_len == 1) begin
                state_d[c] = ST_HIGH;
                rise_d[c]  = 1'b1;
              end else begin
                state_d[c] = ST_RISE;
                cnt_d[c]   = CW'(1);
              end
            end
          end
          ST_RISE: begin
            if (!s[c]) begin
              state_d[c] = ST_LOW;
              cnt_d[c]   = '0;
            end else if (cnt_q[c] == CW'(p_rise_len - 1)) begin
              state_d[c] = ST_HIGH;
              cnt_d[c]   = '0;
              rise_d[c]  = 1'b1;
            end else begin
              cnt_d[c] = cnt_q[c] + CW'(1);
            end
          end
          ST_HIGH: begin
            if (!s[c]) begin
              if (p_fall_len == 1) begin
                state_d[c] = ST_LOW;
                fall_d[c]  = 1'b1;
              end else begin
                state_d[c] = ST_FALL;
                cnt_d[c]   = CW'(1);
              end
            end
          end
          ST_FALL: begin
            if (s[c]) begin
              state_d[c] = ST_HIGH;
              cnt_d[c]   = '0;
            end else if (cnt_q[c] == CW'(p_fall_len - 1)) begin
              state_d[c] = ST_LOW;
              cnt_d[c]   = '0;
              fall_d[c]  = 1'b1;
            end else begin
              cnt_d[c] = cnt_q[c] + CW'(1);
            end
          end
          default: begin
            state_d[c] = ST_INIT;
            cnt_d[c]   = '0;
          end
        endcase
      end
      // Outputs are derived from the next state so they change with the transition edge.
      out_d[c]  = (state_d[c] == ST_HIGH) || (state_d[c] == ST_FALL);
      busy_d[c] = (state_d[c] == ST_RISE) || (state_d[c] == ST_FALL);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      settle_q <= '0;
      out_q    <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      busy_q   <= '0;
      for (int c = 0; c < int'(p_channels); c++) begin
        state_q[c] <= ST_INIT;
        cnt_q[c]   <= '0;
      end
    end else begin
      settle_q <= settle_d;
      out_q    <= out_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      busy_q   <= busy_d;
      for (int c = 0; c < int'(p_channels); c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
    end
  end

  assign o_out  = out_q;
  assign o_rise = rise_q;
  assign o_fall = fall_q;
  assign o_busy = busy_q;

endmodule

// File: tb/tb_schmitt_trigger_bank.sv
// Directed bench: default-parameter bank driven from a vector table, plus a
// second instance with rise/fall length 1 and no synchronizer.
module tb_schmitt_trigger_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [3:0] in_a, out_a, rise_a, fall_a, busy_a;
  logic [3:0] in_b, out_b, rise_b, fall_b, busy_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  schmitt_trigger_bank #(
    .p_channels(4), .p_rise_len(5), .p_fall_len(3), .p_sync(2)
  ) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_tick(tick),
    .i_in  (in_a),
    .o_out (out_a),
    .o_rise(rise_a),
    .o_fall(fall_a),
    .o_busy(busy_a)
  );

  schmitt_trigger_bank #(
    .p_channels(4), .p_rise_len(1), .p_fall_len(1), .p_sync(0)
  ) u_dut_fast (
    .i_clk (clk),
    .i_rst (rst),
    .i_tick(tick),
    .i_in  (in_b),
    .o_out (out_b),
    .o_rise(rise_b),
    .o_fall(fall_b),
    .o_busy(busy_b)
  );

  typedef struct {
    logic [3:0] in;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] busy;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic chk_a(input string name, input int idx, input logic [3:0] eo,
                       input logic [3:0] er, input logic [3:0] ef, input logic [3:0] eb);
    chk({name, ".out"},  idx, out_a,  eo);
    chk({name, ".rise"}, idx, rise_a, er);
    chk({name, ".fall"}, idx, fall_a, ef);
    chk({name, ".busy"}, idx, busy_a, eb);
  endtask

  task automatic chk_b(input string name, input int idx, input logic [3:0] eo,
                       input logic [3:0] er, input logic [3:0] ef);
    chk({name, ".out"},  idx, out_b,  eo);
    chk({name, ".rise"}, idx, rise_b, er);
    chk({name, ".fall"}, idx, fall_b, ef);
    chk({name, ".busy"}, idx, busy_b, 4'b0000);
  endtask

  task automatic add(input logic [3:0] i, input logic [3:0] o, input logic [3:0] r,
                     input logic [3:0] f, input logic [3:0] b, input int rep);
    vec_t v;
    v = '{i, o, r, f, b};
    for (int k = 0; k < rep; k++) vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] pats[5];
    logic [3:0] prev;
    logic [3:0] e_out, e_rise, e_busy;

    // Settle, INIT exit, ch2 fall, ch1 4-sample glitch, ch0 2-sample glitch,
    // ch1 rise, all-fall, all-rise together.
    add(4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2);
    add(4'b0101, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 1);
    add(4'b0001, 4'b0101, 4'b0000, 4'b0000, 4'b0000, 2);
    add(4'b0001, 4'b0101, 4'b0000, 4'b0000, 4'b0100, 2);
    add(4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0000, 1);
    add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1);
    add(4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2);
    add(4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 2);
    add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 2);
    add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2);
    add(4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2);
    add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 2);
    add(4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2);
    add(4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2);
    add(4'b0011, 4'b0001, 4'b0000, 4'b0000, 4'b0010, 4);
    add(4'b0011, 4'b0011, 4'b0010, 4'b0000, 4'b0000, 1);
    add(4'b0011, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1);
    add(4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 2);
    add(4'b0000, 4'b0011, 4'b0000, 4'b0000, 4'b0011, 2);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0011, 4'b0000, 1);
    add(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1);
    add(4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 2);
    add(4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4);
    add(4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 1);
    add(4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 1);

    rst  = 1'b1;
    tick = 1'b1;
    in_a = 4'b0101;
    in_b = 4'b0000;
    step();
    step();
    chk_a("reset", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;

    foreach (vecs[i]) begin
      in_a = vecs[i].in;
      step();
      chk_a("vec", i + 1, vecs[i].out, vecs[i].rise, vecs[i].fall, vecs[i].busy);
    end

    // Slow tick: one sample every 4th clock, ch3 rises on the 5th qualifying tick.
    rst  = 1'b1;
    in_a = 4'b0000;
    step();
    chk_a("reset_clear", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;
    repeat (3) step();
    chk_a("reinit_low", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    in_a = 4'b1000;
    for (int cyc = 0; cyc <= 20; cyc++) begin
      tick = ((cyc % 4) == 3);
      step();
      e_out  = (cyc >= 19) ? 4'b1000 : 4'b0000;
      e_rise = (cyc == 19) ? 4'b1000 : 4'b0000;
      e_busy = (cyc >= 3 && cyc < 19) ? 4'b1000 : 4'b0000;
      chk_a("slow_tick", cyc, e_out, e_rise, 4'b0000, e_busy);
    end
    tick = 1'b1;

    // Reset in the middle of a rise qualification, then INIT exit straight to HIGH.
    rst  = 1'b1;
    in_a = 4'b0000;
    step();
    rst = 1'b0;
    repeat (3) step();
    in_a = 4'b1000;
    step();
    step();
    step();
    step();
    chk_a("mid_rise", 0, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    rst = 1'b1;
    step();
    chk_a("rst_abort", 0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;
    step();
    chk_a("post_rst", 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step();
    chk_a("post_rst", 2, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    step();
    chk_a("post_rst", 3, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
    step();
    chk_a("post_rst", 4, 4'b1000, 4'b0000, 4'b0000, 4'b0000);

    // Length-1, unsynchronized instance follows its input after one clock.
    rst  = 1'b1;
    in_b = 4'b0101;
    step();
    rst = 1'b0;
    step();
    chk_b("fast_init", 0, 4'b0101, 4'b0000, 4'b0000);
    pats = '{4'b1010, 4'b1111, 4'b0000, 4'b0110, 4'b0110};
    prev = 4'b0101;
    for (int i = 0; i < 5; i++) begin
      in_b = pats[i];
      step();
      chk_b("fast", i, pats[i], pats[i] & ~prev, prev & ~pats[i]);
      prev = pats[i];
    end
    tick = 1'b0;
    in_b = 4'b1001;
    step();
    chk_b("fast_notick", 0, 4'b0110, 4'b0000, 4'b0000);
    tick = 1'b1;
    step();
    chk_b("fast_tick", 0, 4'b1001, 4'b1001, 4'b0110);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
